// File: rtl/mux_stim_sequencer.sv
// mux_stim_sequencer
//   Drives stimulus into a 2:1 mux under test. It holds two operand registers
//   and toggles the mux select 0 -> 1 for a programmable number of repetitions,
//   with each select phase held for a programmable number of cycles.
//
//   Optional feature macro: SEQ_CHECK_EN. When it is defined, the block adds a
//   mux_in feedback port and a sticky err flag. err records any cycle in which
//   the mux output does not match the operand that is currently selected.
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   load           capture a_in/b_in (honoured only in IDLE)
//   a_in, b_in     operands to capture
//   start          begin a sequence (honoured only in IDLE)
//   reps           sel 0->1 repetitions, sampled at start
//   hold           cycles per sel phase, sampled at start (0 behaves as 1)
//   a_out, b_out   registered operands feeding the mux
//   sel_out        registered mux select (1 only in SEL1)
//   busy           high outside IDLE
//   done           one-cycle pulse in DONE
//   mux_in, err    (SEQ_CHECK_EN) mux output feedback, sticky mismatch flag
module mux_stim_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             start,
  input  logic [3:0]       reps,
  input  logic [3:0]       hold,
`ifdef SEQ_CHECK_EN
  input  logic [WIDTH-1:0] mux_in,
  output logic             err,
`endif
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             sel_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SEL0, SEL1, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       reps_q, reps_d;   // remaining repetitions
  logic [3:0]       hold_q, hold_d;   // phase length, already clamped to >= 1
  logic [3:0]       phase_q, phase_d; // cycles spent in the current phase
  logic             sel_q, sel_d;
  logic             phase_end;

  // The phase counter starts at 0 on entry, so a phase ends on count hold-1.
  assign phase_end = (phase_q == hold_q - 4'd1);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    reps_d  = reps_q;
    hold_d  = hold_q;
    phase_d = phase_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          a_d = a_in;
          b_d = b_in;
        end
        if (start) begin
          reps_d  = reps;
          hold_d  = (hold == 4'd0) ? 4'd1 : hold;
          phase_d = 4'd0;
          state_d = (reps != 4'd0) ? SEL0 : DONE;
        end
      end
      SEL0: begin
        if (phase_end) begin
          phase_d = 4'd0;
          state_d = SEL1;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      SEL1: begin
        if (phase_end) begin
          phase_d = 4'd0;
          reps_d  = reps_q - 4'd1;
          state_d = (reps_q == 4'd1) ? DONE : SEL0;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      DONE: begin
        reps_d  = 4'd0;
        hold_d  = 4'd0;
        phase_d = 4'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Select is registered from the next state so it lines up with SEL1 exactly.
    sel_d = (state_d == SEL1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      reps_q  <= '0;
      hold_q  <= '0;
      phase_q <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      reps_q  <= reps_d;
      hold_q  <= hold_d;
      phase_q <= phase_d;
      sel_q   <= sel_d;
    end
  end

  assign a_out   = a_q;
  assign b_out   = b_q;
  assign sel_out = sel_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

`ifdef SEQ_CHECK_EN
  logic err_q, err_d;

  // A start clears the flag. Otherwise any mismatch in an active phase sets it
  // and it stays set.
  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && start)
      err_d = 1'b0;
    else if ((state_q == SEL0 && mux_in != a_q) ||
             (state_q == SEL1 && mux_in != b_q))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_mux_stim_sequencer.sv
module tb_mux_stim_sequencer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0, start = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic [3:0]   reps = '0, hold = '0;
  logic [W-1:0] a_out, b_out;
  logic         sel_out, busy, done;
`ifdef SEQ_CHECK_EN
  logic         inject = 1'b0;
  logic [W-1:0] mux_in;
  logic         err;
  // An ideal mux, with an option to corrupt its output.
  assign mux_in = inject ? 8'h55 : (sel_out ? b_out : a_out);
`endif

  mux_stim_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load(load), .a_in(a_in), .b_in(b_in),
    .start(start), .reps(reps), .hold(hold),
`ifdef SEQ_CHECK_EN
    .mux_in(mux_in), .err(err),
`endif
    .a_out(a_out), .b_out(b_out), .sel_out(sel_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         sel;
    logic         done;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  // The reference model is an expected per-cycle trace of the busy period.
  // rem counts down the busy cycles still to come.
  exp_t         q[$];
  int           rem = 0;
  logic [W-1:0] ma = '0, mb = '0;
  logic         exp_err = 1'b0;
  int           checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Applies one rising edge to the model, using the inputs the DUT sees.
  task automatic model_edge();
    int h;
    if (rem != 0) begin
      rem--;
    end else begin
      if (load) begin
        ma = a_in;
        mb = b_in;
      end
      if (start) begin
        h = (hold == 0) ? 1 : int'(hold);
        for (int r = 0; r < int'(reps); r++) begin
          for (int i = 0; i < h; i++) q.push_back('{1'b0, 1'b0, ma, mb});
          for (int i = 0; i < h; i++) q.push_back('{1'b1, 1'b0, ma, mb});
        end
        q.push_back('{1'b0, 1'b1, ma, mb});
        rem = 2 * int'(reps) * h + 1;
        exp_err = 1'b0;
      end
    end
  endtask

  task automatic step(input logic ld, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic st, input logic [3:0] rp, input logic [3:0] hd);
    load = ld; a_in = a; b_in = b; start = st; reps = rp; hold = hd;
    @(posedge clk);
    model_edge();
    #1;
    load = 1'b0;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 4'd0, 4'd0);
  endtask

  // The monitor pops one expected entry for every cycle the DUT reports busy.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("busy", busy, rem != 0);
      if (busy) begin
        if (q.size() == 0) begin
          chk("busy_extra", busy, 1'b0);
        end else begin
          e = q.pop_front();
          chk("sel_out", sel_out, e.sel);
          chk("done", done, e.done);
          chk("a_out_busy", a_out, e.a);
          chk("b_out_busy", b_out, e.b);
        end
      end else begin
        chk("idle_sel", sel_out, 1'b0);
        chk("idle_done", done, 1'b0);
        chk("idle_a", a_out, ma);
        chk("idle_b", b_out, mb);
      end
`ifdef SEQ_CHECK_EN
      chk("err", err, exp_err);
`endif
    end
  end

  initial begin
    // Reset values
    #2;
    chk("rst_a", a_out, 0);
    chk("rst_b", b_out, 0);
    chk("rst_sel", sel_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    #5 rst = 1'b0;

    // Load 00/01, then reps=3 hold=2: 13 busy cycles
    step(1'b1, 8'h00, 8'h01, 1'b0, 4'd0, 4'd0);
    step(1'b0, 8'h00, 8'h00, 1'b1, 4'd3, 4'd2);
    idle(16);

    // reps=0: the DONE cycle only
    step(1'b0, 8'h00, 8'h00, 1'b1, 4'd0, 4'd5);
    idle(3);

    // Load and start together, hold=0 acts as 1
    step(1'b1, 8'h01, 8'h02, 1'b1, 4'd1, 4'd0);
    idle(5);

    // load/start while busy are ignored
    step(1'b0, 8'h00, 8'h00, 1'b1, 4'd2, 4'd3);
    for (int i = 0; i < 4; i++) step(1'b1, 8'hFF, 8'hFF, 1'b1, 4'd1, 4'd1);
    idle(14);

    // Reset during SEL1
    step(1'b1, 8'h10, 8'h20, 1'b1, 4'd2, 4'd2);
    for (int i = 0; i < 50 && !sel_out; i++) idle(1);
    chk("wait_sel1", sel_out, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_a", a_out, 0);
    chk("midrst_b", b_out, 0);
    chk("midrst_sel", sel_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    q.delete();
    rem = 0; ma = '0; mb = '0; exp_err = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    idle(4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
           ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
    end
    idle(25);

`ifdef SEQ_CHECK_EN
    // A corrupted mux output during SEL1 sets err. err stays set through DONE
    // and clears on the next start.
    step(1'b1, 8'h01, 8'h02, 1'b1, 4'd1, 4'd2);
    for (int i = 0; i < 20 && !sel_out; i++) idle(1);
    chk("chk_wait_sel1", sel_out, 1'b1);
    inject = 1'b1;
    idle(1);
    inject = 1'b0;
    exp_err = 1'b1;
    idle(6);
    step(1'b0, 8'h00, 8'h00, 1'b1, 4'd0, 4'd0);
    idle(3);
`endif

    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_stim_sequencer.md
MUX_STIM_SEQUENCER -- requirements
Module: mux_stim_sequencer

Interface
REQ-001 Parameter: WIDTH, default 8, operand and mux data width.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: load  in  1  capture a_in/b_in into the operand registers.
REQ-005 Port: a_in  in  WIDTH  operand A to capture.
REQ-006 Port: b_in  in  WIDTH  operand B to capture.
REQ-007 Port: start  in  1  begin a select-toggle sequence.
REQ-008 Port: reps  in  4  number of sel 0->1 repetitions, sampled at start acceptance.
REQ-009 Port: hold  in  4  cycles per sel phase, sampled at start acceptance; 0 treated as 1.
REQ-010 Port: a_out  out  WIDTH  registered operand A, drives the mux a input.
REQ-011 Port: b_out  out  WIDTH  registered operand B, drives the mux b input.
REQ-012 Port: sel_out  out  1  registered mux select.
REQ-013 Port: busy  out  1  high in any state other than IDLE.
REQ-014 Port: done  out  1  one-cycle pulse at sequence end.
REQ-015 Port (SEQ_CHECK_EN only): mux_in  in  WIDTH  mux output fed back.
REQ-016 Port (SEQ_CHECK_EN only): err  out  1  sticky mismatch flag.

Function
REQ-017 FSM states IDLE, SEL0, SEL1, DONE; sel_out=1 only in SEL1.
REQ-018 load in IDLE: a_out/b_out take a_in/b_in on that edge; load while busy is ignored.
REQ-019 start in IDLE with reps!=0: next cycle state SEL0, busy=1; start while busy ignored.
REQ-020 start in IDLE with reps==0: next cycle DONE, no SEL0/SEL1 visited.
REQ-021 SEL0 and SEL1 each last exactly max(hold,1) cycles, counted by an internal 4-bit phase counter reset on every phase entry.
REQ-022 SEL0 end -> SEL1; SEL1 end -> decrement remaining-reps; if result >0 -> SEL0, else -> DONE.
REQ-023 DONE lasts one cycle: done=1, busy=1, sel_out=0; then IDLE.
REQ-024 load and start in the same IDLE cycle: both accepted; sequence uses newly loaded operands.
REQ-025 Total busy cycles for reps=R>0, hold=H: 2*R*max(H,1)+1.
REQ-026 a_out/b_out never change while busy.

Reset
REQ-027 rst asserted (any state, including mid-sequence) immediately forces IDLE, a_out=0, b_out=0, sel_out=0, busy=0, done=0, err=0, counters 0.
REQ-028 After rst deassertion the block waits in IDLE for start; no sequence resumes.

Configuration
REQ-029 Macro SEQ_CHECK_EN defined: mux_in/err ports exist; every SEL0 cycle mux_in must equal a_out, every SEL1 cycle must equal b_out; mismatch sets err on next edge; err clears only on rst or start acceptance.
REQ-030 SEQ_CHECK_EN undefined: mux_in/err ports and checker logic absent; all other behaviour identical.

Verification
REQ-031 Reset mid-sequence: rst pulse during SEL1 -> all outputs 0 asynchronously, state IDLE, no done pulse.
REQ-032 load a_in=8'h00, b_in=8'h01, then start reps=3, hold=2 -> sel_out 0,0,1,1 repeated 3 times, done one cycle later, busy 13 cycles.
REQ-033 start reps=0 -> done pulse on the next cycle, sel_out stays 0, busy 1 cycle.
REQ-034 load 8'h01/8'h02 concurrent with start reps=1, hold=0 -> a_out=8'h01, b_out=8'h02, sel 0 then 1 one cycle each, done pulse.
REQ-035 load 8'hFF during busy -> a_out/b_out unchanged; start during busy -> no restart, done timing unchanged.
REQ-036 SEQ_CHECK_EN: mux_in forced 8'h55 while SEL1 with b_out=8'h02 -> err=1 next edge, holds through DONE, clears on next start.
